uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single uart_transmitter between NUM_REQ byte-stream producers (debug peripheral responses, CPU console MMIO, ...).
//  Each requester pushes bytes plus an end-of-packet flag into its own FIFO.
//  A round-robin scheduler grants one complete packet at a time and drives the transmitter DV/Done handshake.
//  Packets are never interleaved on the wire.
// PARAMETERS
//  NUM_REQ          2   number of requesters, 2..4
//  FIFO_DEPTH_LOG2  4   log2 of per-requester FIFO depth (entries = 9-bit {last,byte})
// PORTS
//  i_Clock            in   1          system clock; single clock domain
//  i_Reset            in   1          asynchronous, active-high reset
//  i_Wr_En            in   NUM_REQ    per-requester push strobe
//  i_Wr_Byte          in   8*NUM_REQ  push data; requester k at [8k+7:8k]
//  i_Wr_Last          in   NUM_REQ    pushed byte ends a packet
//  o_Full             out  NUM_REQ    FIFO k full; a push while full is dropped
//  o_Overflow         out  NUM_REQ    sticky: a push to FIFO k was dropped
//  i_Clear_Overflow   in   NUM_REQ    clears o_Overflow[k]; a coincident drop wins
//  o_Grant            out  NUM_REQ    one-hot owner of the current packet; 0 when idle
//  o_Busy             out  1          high whenever state != IDLE
//  o_Tx_DV            out  1          to uart_transmitter i_Tx_DV
//  o_Tx_Byte          out  8          to uart_transmitter i_Tx_Byte
//  i_Tx_Done          in   1          from uart_transmitter o_Tx_Done
// BEHAVIOUR
//  Reset: all outputs 0; FIFOs empty; packet counts 0; round-robin pointer = NUM_REQ-1 (requester 0 has first priority).
//   Reset is asynchronous. Asserting it mid-packet drops o_Tx_DV at once and discards all queued data.
//  FIFO k:
//   - A push is accepted iff i_Wr_En[k] && !o_Full[k].
//   - A pop is issued only by the scheduler.
//   - Simultaneous push and pop are both performed and occupancy is unchanged; a push is accepted when full only if a pop occurs in the same cycle.
//   - Pointers wrap modulo depth.
//  pkt_cnt[k]:
//   - +1 on an accepted push with last set; -1 when a byte with last set is popped; both in one cycle = no change.
//   - A dropped push never changes pkt_cnt.
//  A requester is eligible iff pkt_cnt[k] != 0. Partial packets are never granted.
//  FSM:
//   IDLE  - If any requester is eligible, grant the first eligible one after the rr pointer, wrapping.
//           Set o_Grant and rr pointer = k; go TAG if the feature is enabled, else LOAD.
//   LOAD  - Pop the FIFO head into o_Tx_Byte, latch its last flag, o_Tx_DV <= 1; go SEND.
//   SEND  - Hold o_Tx_DV and o_Tx_Byte stable until i_Tx_Done.
//           On i_Tx_Done: o_Tx_DV <= 0; if the latched last flag is set, o_Grant <= 0 and go IDLE, else go GAP.
//   GAP   - One cycle with o_Tx_DV low, then LOAD. Guarantees DV is low for at least 1 cycle between bytes.
//  Latency:
//   - Last byte pushed in cycle N with the arbiter idle -> eligible in N+1 -> grant in N+1 -> o_Tx_DV high in N+2 (no tag).
//   - Back-to-back packets: IDLE costs 1 cycle between the last Done and the next grant.
//  i_Tx_Done outside SEND is ignored. A byte pushed to the granted FIFO mid-packet is appended normally.
//  Partial packets:
//   - A packet whose last-flagged byte was dropped merges with the requester's next packet.
//   - Software must check o_Overflow.
// CONFIGURATION
//  Macro UART_TX_ARB_TAG_EN:
//   Defined: FSM adds state TAG between IDLE and LOAD.
//     - TAG sends one header byte TAG_BASE|k (TAG_BASE = 8'hF0) with the same SEND/GAP handshake.
//     - The granted requester's data follows; the tag does not pop its FIFO.
//   Undefined: no TAG state and no header byte; only raw packet bytes are sent.
// STRUCTURE
//  Shared header uart_tx_arbiter.vh, next to debug_peripheral.vh:
//   - State encodings s_ARB_IDLE, s_ARB_TAG, s_ARB_LOAD, s_ARB_SEND, s_ARB_GAP.
//   - ARB_TAG_BASE = 8'hF0.
//  Sub-module byte_fifo:
//   - Synchronous 9-bit wide FIFO, depth 2**FIFO_DEPTH_LOG2, async reset.
//   - Ports: push, pop, din, dout (first-word-fall-through), full, empty.
//   - Instantiated NUM_REQ times via generate.
//  The scheduler, pkt_cnt registers and overflow flags live in this module.
// TESTING
//  1. Req0 pushes 8'h41,8'h42(last); Done returned 3 cycles after each DV rise
//     -> o_Tx_Byte 41 then 42, o_Grant=01 throughout, DV low >=1 cycle between bytes, o_Busy=0 after.
//  2. Req0 and Req1 each hold two 2-byte packets, pushed while busy
//     -> wire order R0,R1,R0,R1 packets; bytes never interleave.
//  3. Depth 16: push 17 bytes to req1 with no pop
//     -> o_Full[1]=1 after 16, 17th dropped, o_Overflow[1]=1 until i_Clear_Overflow[1].
//  4. Req0 pushes 3 bytes without last -> no grant, o_Tx_DV stays 0; push last byte -> packet of 4 sent.
//  5. Assert i_Reset while in SEND on byte 2 of 4 -> o_Tx_DV=0 same cycle; after release FIFOs empty, no transmission.
//  6. With UART_TX_ARB_TAG_EN: req1 packet 8'h55(last) -> wire bytes F1 then 55.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared state encodings and constants for uart_tx_arbiter
// s_ARB_TAG and ARB_TAG_BASE are only exercised when UART_TX_ARB_TAG_EN is defined.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    s_ARB_IDLE = 3'd0,
    s_ARB_TAG  = 3'd1,
    s_ARB_LOAD = 3'd2,
    s_ARB_SEND = 3'd3,
    s_ARB_GAP  = 3'd4
  } arb_state_t;

  localparam logic [7:0] ARB_TAG_BASE = 8'hF0;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - 9-bit {last,byte} first-word-fall-through FIFO, async active-high reset
module byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [8:0] i_din,
  output logic [8:0] o_dout,
  output logic       o_full,
  output logic       o_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [8:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_do_pop;
  logic                  w_do_push;

  // A full FIFO still takes a push when the same cycle frees a slot.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rd_ptr];

  always_ff @(posedge i_Clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter in front of one uart_transmitter
// Define UART_TX_ARB_TAG_EN to prefix each packet with header byte ARB_TAG_BASE|requester.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic [NUM_REQ-1:0]     i_Wr_En,
  input  logic [8*NUM_REQ-1:0]   i_Wr_Byte,
  input  logic [NUM_REQ-1:0]     i_Wr_Last,
  output logic [NUM_REQ-1:0]     o_Full,
  output logic [NUM_REQ-1:0]     o_Overflow,
  input  logic [NUM_REQ-1:0]     i_Clear_Overflow,
  output logic [NUM_REQ-1:0]     o_Grant,
  output logic                   o_Busy,
  output logic                   o_Tx_DV,
  output logic [7:0]             o_Tx_Byte,
  input  logic                   i_Tx_Done
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;

  arb_state_t         r_state;
  arb_state_t         w_next;
  logic [IW-1:0]      r_rr;
  logic [IW-1:0]      w_pick;
  logic               w_any;
  logic               r_last;
  logic [8:0]         w_dout [NUM_REQ];
  logic [NUM_REQ-1:0] w_empty;
  logic [NUM_REQ-1:0] w_pop;
  logic [NUM_REQ-1:0] w_push_ok;
  logic [NUM_REQ-1:0] w_eligible;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    logic [FIFO_DEPTH_LOG2:0] r_pkt_cnt;
    logic                     r_ovf;
    logic                     w_inc;
    logic                     w_dec;
    logic                     w_drop;

    byte_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .i_push  (i_Wr_En[g]),
      .i_pop   (w_pop[g]),
      .i_din   ({i_Wr_Last[g], i_Wr_Byte[8*g +: 8]}),
      .o_dout  (w_dout[g]),
      .o_full  (o_Full[g]),
      .o_empty (w_empty[g])
    );

    assign w_pop[g]      = (r_state == s_ARB_LOAD) && o_Grant[g] && !w_empty[g];
    assign w_push_ok[g]  = i_Wr_En[g] && (!o_Full[g] || w_pop[g]);
    assign w_inc         = w_push_ok[g] && i_Wr_Last[g];
    assign w_dec         = w_pop[g] && w_dout[g][8];
    assign w_drop        = i_Wr_En[g] && !w_push_ok[g];
    assign w_eligible[g] = (r_pkt_cnt != '0);
    assign o_Overflow[g] = r_ovf;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
        r_pkt_cnt <= '0;
        r_ovf     <= 1'b0;
      end else begin
        if (w_inc && !w_dec)      r_pkt_cnt <= r_pkt_cnt + 1'b1;
        else if (w_dec && !w_inc) r_pkt_cnt <= r_pkt_cnt - 1'b1;
        if (w_drop)                      r_ovf <= 1'b1;
        else if (i_Clear_Overflow[g])    r_ovf <= 1'b0;
      end
    end
  end

  // Scan offsets from the far end so the nearest eligible requester after r_rr wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_rr;
    for (int i = NUM_REQ; i >= 1; i--) begin
      int idx;
      idx = (int'(r_rr) + i) % NUM_REQ;
      if (w_eligible[idx]) begin
        w_any  = 1'b1;
        w_pick = IW'(idx);
      end
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) r_state <= s_ARB_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      s_ARB_IDLE: begin
        if (w_any) begin
`ifdef UART_TX_ARB_TAG_EN
          w_next = s_ARB_TAG;
`else
          w_next = s_ARB_LOAD;
`endif
        end
      end
      s_ARB_TAG:  w_next = s_ARB_SEND;
      s_ARB_LOAD: w_next = s_ARB_SEND;
      s_ARB_SEND: if (i_Tx_Done) w_next = r_last ? s_ARB_IDLE : s_ARB_GAP;
      s_ARB_GAP:  w_next = s_ARB_LOAD;
      default:    w_next = s_ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_Grant   <= '0;
      r_rr      <= IW'(NUM_REQ - 1);
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= '0;
      r_last    <= 1'b0;
    end else begin
      case (r_state)
        s_ARB_IDLE: begin
          if (w_any) begin
            o_Grant <= NUM_REQ'(1) << w_pick;
            r_rr    <= w_pick;
          end
        end
`ifdef UART_TX_ARB_TAG_EN
        s_ARB_TAG: begin
          o_Tx_Byte <= ARB_TAG_BASE | 8'(r_rr);
          r_last    <= 1'b0;
          o_Tx_DV   <= 1'b1;
        end
`endif
        s_ARB_LOAD: begin
          o_Tx_Byte <= w_dout[r_rr][7:0];
          r_last    <= w_dout[r_rr][8];
          o_Tx_DV   <= 1'b1;
        end
        s_ARB_SEND: begin
          if (i_Tx_Done) begin
            o_Tx_DV <= 1'b0;
            if (r_last) o_Grant <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_Busy = (r_state != s_ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized self-checking bench for uart_tx_arbiter against a queue model
module tb_uart_tx_arbiter;

`ifdef UART_TX_ARB_TAG_EN
  localparam int T = 1;
`else
  localparam int T = 0;
`endif

  logic        i_Clock = 1'b0;
  logic        i_Reset;
  logic [1:0]  i_Wr_En;
  logic [15:0] i_Wr_Byte;
  logic [1:0]  i_Wr_Last;
  logic [1:0]  i_Clear_Overflow;
  logic        i_Tx_Done;
  logic [1:0]  o_Full, o_Overflow, o_Grant;
  logic        o_Busy, o_Tx_DV;
  logic [7:0]  o_Tx_Byte;

  always #5 i_Clock = ~i_Clock;

  uart_tx_arbiter #(.NUM_REQ(2), .FIFO_DEPTH_LOG2(4)) dut (
    .i_Clock          (i_Clock),
    .i_Reset          (i_Reset),
    .i_Wr_En          (i_Wr_En),
    .i_Wr_Byte        (i_Wr_Byte),
    .i_Wr_Last        (i_Wr_Last),
    .o_Full           (o_Full),
    .o_Overflow       (o_Overflow),
    .i_Clear_Overflow (i_Clear_Overflow),
    .o_Grant          (o_Grant),
    .o_Busy           (o_Busy),
    .o_Tx_DV          (o_Tx_DV),
    .o_Tx_Byte        (o_Tx_Byte),
    .i_Tx_Done        (i_Tx_Done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: per-requester queues of accepted {last,byte} entries, plus the observed wire log.
  logic [8:0] mq0[$];
  logic [8:0] mq1[$];
  logic [9:0] log_q[$];
  int         sent = 0;

  function automatic int msize(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic mcomplete(input int k);
    logic c;
    c = 1'b0;
    if (k == 0) begin foreach (mq0[i]) if (mq0[i][8]) c = 1'b1; end
    else        begin foreach (mq1[i]) if (mq1[i][8]) c = 1'b1; end
    return c;
  endfunction

  task automatic mclear();
    mq0.delete();
    mq1.delete();
  endtask

  task automatic push(input logic [1:0] en, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [1:0] last, input logic [1:0] clr);
    @(posedge i_Clock); #1;
    i_Wr_En = en; i_Wr_Byte = {b1, b0}; i_Wr_Last = last; i_Clear_Overflow = clr;
    @(posedge i_Clock);
    if (en[0] && mq0.size() < 16) mq0.push_back({last[0], b0});
    if (en[1] && mq1.size() < 16) mq1.push_back({last[1], b1});
    #1;
    i_Wr_En = '0; i_Wr_Last = '0; i_Clear_Overflow = '0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge i_Clock); #1;
      if (!o_Busy && !o_Tx_DV && !mcomplete(0) && !mcomplete(1)) return;
    end
    check("drain_timeout", 0, 1);
  endtask

  task automatic exp_at(input string tag, input int idx, input logic [1:0] g, input logic [7:0] b);
    if (idx < log_q.size()) check(tag, {22'd0, log_q[idx]}, {22'd0, g, b});
    else                    check(tag, 32'hDEAD, {22'd0, g, b});
  endtask

  // Transmitter stand-in: Done pulses for one cycle 1..3 cycles after DV is seen high.
  initial begin
    int  wait_cnt;
    bit  armed;
    armed = 0; wait_cnt = 0;
    i_Tx_Done = 1'b0;
    forever begin
      @(posedge i_Clock); #1;
      i_Tx_Done = 1'b0;
      if (o_Tx_DV && !i_Reset) begin
        if (!armed) begin
          armed = 1; wait_cnt = $urandom_range(1, 3);
        end else begin
          wait_cnt--;
          if (wait_cnt == 0) begin i_Tx_Done = 1'b1; armed = 0; end
        end
      end else begin
        armed = 0;
      end
    end
  end

  // Wire monitor: every DV rise is one byte; compare against the model queues.
  initial begin
    logic       prev_dv, done_seen, in_pkt;
    logic [1:0] owner;
    logic [8:0] e;
    int         k;
    prev_dv = 0; done_seen = 0; in_pkt = 0; owner = 0;
    forever begin
      @(negedge i_Clock);
      if (i_Reset) begin
        prev_dv = 0; done_seen = 0; in_pkt = 0;
      end else begin
        if (done_seen) check("dv_low_after_done", {31'd0, o_Tx_DV}, 0);
        done_seen = i_Tx_Done;
        if (o_Tx_DV && !prev_dv) begin
          sent++;
          log_q.push_back({o_Grant, o_Tx_Byte});
          check("grant_onehot", {31'd0, $onehot(o_Grant)}, 1);
          k = o_Grant[1] ? 1 : 0;
          if (!in_pkt) begin
            check("grant_eligible", {31'd0, mcomplete(k)}, 1);
            owner  = o_Grant;
            in_pkt = 1;
`ifdef UART_TX_ARB_TAG_EN
            check("tag_byte", {24'd0, o_Tx_Byte}, 32'hF0 | k);
            prev_dv = o_Tx_DV;
            continue;
`endif
          end else begin
            check("grant_stable", {30'd0, o_Grant}, {30'd0, owner});
          end
          if (msize(k) == 0) begin
            check("model_underflow", {24'd0, o_Tx_Byte}, 32'h100);
          end else begin
            e = (k == 0) ? mq0.pop_front() : mq1.pop_front();
            check("tx_byte", {24'd0, o_Tx_Byte}, {24'd0, e[7:0]});
            if (e[8]) in_pkt = 0;
          end
        end
        prev_dv = o_Tx_DV;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int         base;
    logic [1:0] open;
    logic [1:0] en, last;
    i_Reset = 1'b1; i_Wr_En = '0; i_Wr_Byte = '0; i_Wr_Last = '0; i_Clear_Overflow = '0;
    repeat (3) @(posedge i_Clock);
    #1;
    check("rst_dv", {31'd0, o_Tx_DV}, 0);
    check("rst_grant", {30'd0, o_Grant}, 0);
    check("rst_busy", {31'd0, o_Busy}, 0);
    check("rst_full", {30'd0, o_Full}, 0);
    check("rst_ovf", {30'd0, o_Overflow}, 0);
    check("rst_byte", {24'd0, o_Tx_Byte}, 0);
    i_Reset = 1'b0;

    // Two packets each from req0 and req1, later ones pushed while busy.
    base = log_q.size();
    push(2'b11, 8'h10, 8'h20, 2'b00, 2'b00);
    push(2'b11, 8'h11, 8'h21, 2'b11, 2'b00);
    push(2'b11, 8'h12, 8'h22, 2'b00, 2'b00);
    push(2'b11, 8'h13, 8'h23, 2'b11, 2'b00);
    wait_idle(500);
    check("t2_count", log_q.size() - base, 8 + 4 * T);
    exp_at("t2_p0", base + T,         2'b01, 8'h10);
    exp_at("t2_p1", base + 1 + T,     2'b01, 8'h11);
    exp_at("t2_p2", base + 2 + 2 * T, 2'b10, 8'h20);
    exp_at("t2_p3", base + 3 + 2 * T, 2'b10, 8'h21);
    exp_at("t2_p4", base + 4 + 3 * T, 2'b01, 8'h12);
    exp_at("t2_p5", base + 5 + 3 * T, 2'b01, 8'h13);
    exp_at("t2_p6", base + 6 + 4 * T, 2'b10, 8'h22);
    exp_at("t2_p7", base + 7 + 4 * T, 2'b10, 8'h23);

    // Single two-byte packet from req0.
    base = log_q.size();
    push(2'b01, 8'h41, 8'h00, 2'b00, 2'b00);
    push(2'b01, 8'h42, 8'h00, 2'b01, 2'b00);
    wait_idle(200);
    check("t1_count", log_q.size() - base, 2 + T);
    exp_at("t1_b0", base + T,     2'b01, 8'h41);
    exp_at("t1_b1", base + 1 + T, 2'b01, 8'h42);
    check("t1_busy", {31'd0, o_Busy}, 0);
    check("t1_grant", {30'd0, o_Grant}, 0);

    // Fill req1 with 16 partial bytes, then overflow.
    for (int i = 0; i < 16; i++) push(2'b10, 8'h00, 8'(8'h80 + i), 2'b00, 2'b00);
    check("t3_full", {30'd0, o_Full}, 2'b10);
    check("t3_ovf_pre", {30'd0, o_Overflow}, 0);
    push(2'b10, 8'h00, 8'hEE, 2'b10, 2'b00);
    check("t3_ovf_set", {30'd0, o_Overflow}, 2'b10);
    check("t3_still_full", {30'd0, o_Full}, 2'b10);
    check("t3_no_grant", {30'd0, o_Grant}, 0);
    push(2'b10, 8'h00, 8'hEF, 2'b00, 2'b10);
    check("t3_drop_wins", {30'd0, o_Overflow}, 2'b10);
    push(2'b00, 8'h00, 8'h00, 2'b00, 2'b10);
    check("t3_ovf_clr", {30'd0, o_Overflow}, 0);
    @(negedge i_Clock); i_Reset = 1'b1; mclear();
    @(negedge i_Clock); i_Reset = 1'b0;
    check("t3_full_after_rst", {30'd0, o_Full}, 0);

    // Partial packet must not be granted until its last byte arrives.
    base = log_q.size();
    for (int i = 0; i < 3; i++) push(2'b01, 8'(8'h60 + i), 8'h00, 2'b00, 2'b00);
    repeat (10) @(negedge i_Clock);
    check("t4_no_dv", {31'd0, o_Tx_DV}, 0);
    check("t4_no_grant", {30'd0, o_Grant}, 0);
    push(2'b01, 8'h63, 8'h00, 2'b01, 2'b00);
    wait_idle(300);
    check("t4_count", log_q.size() - base, 4 + T);

    // Reset while the second of four bytes is in flight.
    base = sent;
    for (int i = 0; i < 4; i++) push(2'b01, 8'(8'h70 + i), 8'h00, {1'b0, i == 3}, 2'b00);
    for (int i = 0; i < 300; i++) begin
      @(negedge i_Clock); #2;
      if (sent >= base + 2 + T) break;
    end
    check("t5_reached", sent - base, 2 + T);
    check("t5_dv_before", {31'd0, o_Tx_DV}, 1);
    i_Reset = 1'b1; mclear();
    #1;
    check("t5_dv_async", {31'd0, o_Tx_DV}, 0);
    check("t5_grant_async", {30'd0, o_Grant}, 0);
    check("t5_busy_async", {31'd0, o_Busy}, 0);
    @(negedge i_Clock); i_Reset = 1'b0;
    base = sent;
    repeat (40) @(negedge i_Clock);
    check("t5_no_tx", sent - base, 0);
    check("t5_idle", {31'd0, o_Busy}, 0);

`ifdef UART_TX_ARB_TAG_EN
    base = log_q.size();
    push(2'b10, 8'h00, 8'h55, 2'b10, 2'b00);
    wait_idle(200);
    exp_at("t6_tag", base,     2'b10, 8'hF1);
    exp_at("t6_data", base + 1, 2'b10, 8'h55);
`endif

    // Random traffic on both requesters, depth kept below full.
    open = 2'b00;
    for (int it = 0; it < 60; it++) begin
      en   = 2'($urandom_range(0, 3));
      last = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      if (msize(0) >= 12) en[0] = 1'b0;
      if (msize(1) >= 12) en[1] = 1'b0;
      push(en, 8'($urandom), 8'($urandom), last & en, 2'b00);
      for (int k = 0; k < 2; k++) if (en[k]) open[k] = !last[k];
      repeat ($urandom_range(0, 3)) @(posedge i_Clock);
    end
    if (open != 2'b00) push(open, 8'hA0, 8'hA1, open, 2'b00);
    wait_idle(3000);
    check("rand_model_empty", msize(0) + msize(1), 0);
    check("rand_idle", {31'd0, o_Busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
